// File: rtl/eth_parser_pkg.sv
// Shared ethernet types and constants used by the frame filter and its neighbours.
package eth_parser_pkg;

  typedef logic [47:0] mac_addr_t;

  typedef struct packed {
    mac_addr_t dest_mac;
    logic      is_ipv4;
    logic      is_ipv6;
    logic      is_arp;
    logic      is_unknown;
  } eth_metadata_t;

  localparam mac_addr_t MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

  // Bit positions inside cfg_proto_en
  localparam int PROTO_EN_IPV4    = 0;
  localparam int PROTO_EN_IPV6    = 1;
  localparam int PROTO_EN_ARP     = 2;
  localparam int PROTO_EN_UNKNOWN = 3;

  // Group bit is the LSB of the first (most significant) octet
  function automatic logic mac_is_mcast(input mac_addr_t mac);
    return mac[40];
  endfunction

endpackage

// File: rtl/eth_frame_filter_if.sv
// AXI-stream style beat bus used on both sides of the frame filter.
interface eth_frame_filter_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/eth_hold_fifo.sv
// First-word-fall-through FIFO holding the head of a frame until it is judged.
module eth_hold_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write; contents need no reset since the pointers qualify them
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  // Pointer update; clear discards everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/eth_frame_filter.sv
// Holds the head of each frame until parser metadata arrives, then forwards or drops it.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a frame
//   HOLD  | buffering head beats, no decision yet
//   PASS  | frame accepted, beats stream through the FIFO
//   DROP  | frame rejected, beats discarded until tlast
//   DRAIN | whole frame received, emptying the FIFO (only if passed)
module eth_frame_filter
  import eth_parser_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HOLD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  eth_frame_filter_if.slave   s_axis,
  input  eth_metadata_t       s_meta,
  input  logic                s_meta_valid,
  input  mac_addr_t           cfg_local_mac,
  input  logic                cfg_promisc,
  input  logic                cfg_mcast_en,
  input  logic [3:0]          cfg_proto_en,
  eth_frame_filter_if.master  m_axis,
  output logic [31:0]         stat_passed,
  output logic [31:0]         stat_dropped,
  output logic [31:0]         stat_runt
);

  typedef enum logic [2:0] {ST_IDLE, ST_HOLD, ST_PASS, ST_DROP, ST_DRAIN} state_t;

  state_t          state_q, state_d;
  logic            passed_q, passed_d;
  logic [31:0]     passed_cnt_q, dropped_cnt_q, runt_cnt_q;
  logic            fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [DATA_WIDTH:0] fifo_dout;
  logic            rdy_raw, s_ready, s_acc, s_last_acc, m_valid;
  logic            mac_ok, proto_ok, pass_dec, inc_dropped, inc_runt;

  eth_hold_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(HOLD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({s_axis.tlast, s_axis.tdata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Forwarding decision from the current metadata
  always_comb begin
    mac_ok = cfg_promisc || (s_meta.dest_mac == cfg_local_mac) ||
             (s_meta.dest_mac == MAC_BROADCAST) ||
             (mac_is_mcast(s_meta.dest_mac) && cfg_mcast_en);
    proto_ok = 1'b0;
    if (s_meta.is_ipv4)      proto_ok = cfg_proto_en[PROTO_EN_IPV4];
    else if (s_meta.is_ipv6) proto_ok = cfg_proto_en[PROTO_EN_IPV6];
    else if (s_meta.is_arp)  proto_ok = cfg_proto_en[PROTO_EN_ARP];
    else if (s_meta.is_unknown) proto_ok = cfg_proto_en[PROTO_EN_UNKNOWN];
  end
  assign pass_dec = mac_ok && proto_ok;

  // Ingress ready depends only on state and FIFO level, never on tvalid
  always_comb begin
    rdy_raw = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DROP: rdy_raw = 1'b1;
      ST_HOLD, ST_PASS: rdy_raw = !fifo_full;
      default:          rdy_raw = 1'b0;
    endcase
  end
  assign s_ready       = rdy_raw && !rst;
  assign s_axis.tready = s_ready;
  assign s_acc         = s_axis.tvalid && s_ready;
  assign s_last_acc    = s_acc && s_axis.tlast;

  assign m_valid       = !rst && !fifo_empty &&
                         ((state_q == ST_PASS) || ((state_q == ST_DRAIN) && passed_q));
  assign fifo_pop      = m_valid && m_axis.tready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
  assign m_axis.tlast  = m_valid && fifo_dout[DATA_WIDTH];

  // Next-state logic; a decision arriving with tlast takes priority over the runt path
  always_comb begin
    state_d     = state_q;
    passed_d    = passed_q;
    fifo_push   = 1'b0;
    fifo_clr    = 1'b0;
    inc_dropped = 1'b0;
    inc_runt    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        fifo_push = s_acc;
        if (s_meta_valid && ((state_q == ST_HOLD) || s_acc)) begin
          passed_d = pass_dec;
          if (pass_dec) begin
            state_d = s_last_acc ? ST_DRAIN : ST_PASS;
          end else begin
            fifo_clr = 1'b1;
            if (s_last_acc) begin
              inc_dropped = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_DROP;
            end
          end
        end else if (s_last_acc) begin
          fifo_clr = 1'b1;
          inc_runt = 1'b1;
          state_d  = ST_IDLE;
        end else if (s_acc) begin
          state_d = ST_HOLD;
        end
      end
      ST_PASS: begin
        fifo_push = s_acc;
        if (s_last_acc) state_d = ST_DRAIN;
      end
      ST_DROP: begin
        if (s_last_acc) begin
          inc_dropped = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!passed_q) begin
          fifo_clr = 1'b1;
          state_d  = ST_IDLE;
        end else if (fifo_empty) begin
          passed_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and frame counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      passed_q      <= 1'b0;
      passed_cnt_q  <= '0;
      dropped_cnt_q <= '0;
      runt_cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      passed_q <= passed_d;
      if (fifo_pop && fifo_dout[DATA_WIDTH]) passed_cnt_q <= passed_cnt_q + 32'd1;
      if (inc_dropped) dropped_cnt_q <= dropped_cnt_q + 32'd1;
      if (inc_runt)    runt_cnt_q    <= runt_cnt_q + 32'd1;
    end
  end

  assign stat_passed  = passed_cnt_q;
  assign stat_dropped = dropped_cnt_q;
  assign stat_runt    = runt_cnt_q;

endmodule

// File: tb/tb_eth_frame_filter.sv
// Directed bench for eth_frame_filter: inputs change 1 time unit after posedge,
// outputs are observed on the negedge.
module tb_eth_frame_filter;
  import eth_parser_pkg::*;

  localparam mac_addr_t LOCAL_MAC = 48'h02_00_00_00_00_01;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  eth_metadata_t meta;
  logic          meta_valid = 1'b0;
  logic          promisc = 1'b0, mcast_en = 1'b0;
  logic [3:0]    proto_en = 4'b0001;
  logic [31:0]   st_passed, st_dropped, st_runt;

  int checks = 0;
  int errors = 0;
  logic [64:0] got[$];
  int mvalid_cycles = 0;

  eth_frame_filter_if #(.DATA_WIDTH(64)) s_if ();
  eth_frame_filter_if #(.DATA_WIDTH(64)) m_if ();

  eth_frame_filter #(.DATA_WIDTH(64), .HOLD_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis        (s_if),
    .s_meta        (meta),
    .s_meta_valid  (meta_valid),
    .cfg_local_mac (LOCAL_MAC),
    .cfg_promisc   (promisc),
    .cfg_mcast_en  (mcast_en),
    .cfg_proto_en  (proto_en),
    .m_axis        (m_if),
    .stat_passed   (st_passed),
    .stat_dropped  (st_dropped),
    .stat_runt     (st_runt)
  );

  always #5 clk = ~clk;

  // Record every beat that will transfer at the coming posedge
  always @(negedge clk) begin
    if (!rst) begin
      if (m_if.tvalid) mvalid_cycles++;
      if (m_if.tvalid && m_if.tready) got.push_back({m_if.tlast, m_if.tdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind bits: {unknown, arp, ipv6, ipv4}
  task automatic set_meta(input mac_addr_t dest, input logic [3:0] kind);
    meta.dest_mac   = dest;
    meta.is_ipv4    = kind[0];
    meta.is_ipv6    = kind[1];
    meta.is_arp     = kind[2];
    meta.is_unknown = kind[3];
  endtask

  // Present beats base+0..base+n-1; meta pulses on cycle meta_cyc (-1 = never)
  task automatic drive_frame(input int n, input logic [63:0] base, input int meta_cyc,
                             output int stalls, output int first_stall, output bit tmo);
    int beat = 0;
    int cyc  = 0;
    stalls = 0; first_stall = -1; tmo = 1'b0;
    while (beat < n && cyc < 200) begin
      s_if.tdata  = base + 64'(beat);
      s_if.tvalid = 1'b1;
      s_if.tlast  = (beat == n - 1);
      meta_valid  = (cyc == meta_cyc);
      @(negedge clk);
      if (s_if.tready) beat++;
      else begin
        if (first_stall < 0) first_stall = beat;
        stalls++;
      end
      step();
      cyc++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    meta_valid  = 1'b0;
    if (beat < n) tmo = 1'b1;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (got.size() < n && k < 100) begin
      step();
      k++;
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
    m_if.tready = 1'b1;
    set_meta(LOCAL_MAC, 4'b0001);
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b want 0", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b want 0", m_if.tvalid); end
    checks++; if (m_if.tdata !== 64'd0) begin errors++; $display("FAIL rst_m_tdata: got %h want 0", m_if.tdata); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast: got %b want 0", m_if.tlast); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (st_passed !== 32'd0) begin errors++; $display("FAIL rst_passed: got %0d want 0", st_passed); end
    checks++; if (st_dropped !== 32'd0) begin errors++; $display("FAIL rst_dropped: got %0d want 0", st_dropped); end
    checks++; if (st_runt !== 32'd0) begin errors++; $display("FAIL rst_runt: got %0d want 0", st_runt); end
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL idle_s_tready: got %b want 1", s_if.tready); end
    step();
  endtask

  task automatic test_local_pass();
    int st, fs; bit tmo;
    got.delete();
    set_meta(LOCAL_MAC, 4'b0001);
    drive_frame(8, 64'h1000, 1, st, fs, tmo);
    wait_out(8);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL local_timeout: got %b want 0", tmo); end
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL local_count: got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {(i == 7), 64'h1000 + 64'(i)})
        begin errors++; $display("FAIL local_beat%0d: got %h want %h", i, got[i], {(i == 7), 64'h1000 + 64'(i)}); end
    end
    checks++; if (st_passed !== 32'd1) begin errors++; $display("FAIL local_passed: got %0d want 1", st_passed); end
  endtask

  task automatic test_drop();
    int st, fs; bit tmo;
    got.delete(); mvalid_cycles = 0;
    set_meta(48'h02_00_00_00_00_99, 4'b0001);
    drive_frame(6, 64'h2000, 1, st, fs, tmo);
    repeat (4) step();
    checks++; if (st !== 0) begin errors++; $display("FAIL drop_stalls: got %0d want 0", st); end
    checks++; if (mvalid_cycles !== 0) begin errors++; $display("FAIL drop_tvalid_cycles: got %0d want 0", mvalid_cycles); end
    checks++; if (st_dropped !== 32'd1) begin errors++; $display("FAIL drop_dropped: got %0d want 1", st_dropped); end
    checks++; if (st_passed !== 32'd1) begin errors++; $display("FAIL drop_passed: got %0d want 1", st_passed); end
  endtask

  task automatic test_backpressure();
    int st, fs; bit tmo;
    got.delete();
    set_meta(LOCAL_MAC, 4'b0001);
    drive_frame(8, 64'h3000, 5, st, fs, tmo);
    wait_out(8);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b want 0", tmo); end
    checks++; if (fs !== 4) begin errors++; $display("FAIL bp_first_stall_beat: got %0d want 4", fs); end
    checks++; if (st !== 3) begin errors++; $display("FAIL bp_stalls: got %0d want 3", st); end
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {(i == 7), 64'h3000 + 64'(i)})
        begin errors++; $display("FAIL bp_beat%0d: got %h want %h", i, got[i], {(i == 7), 64'h3000 + 64'(i)}); end
    end
    checks++; if (st_passed !== 32'd2) begin errors++; $display("FAIL bp_passed: got %0d want 2", st_passed); end
  endtask

  task automatic test_runt();
    int st, fs; bit tmo;
    got.delete(); mvalid_cycles = 0;
    set_meta(LOCAL_MAC, 4'b0001);
    drive_frame(2, 64'h4000, -1, st, fs, tmo);
    repeat (4) step();
    checks++; if (st_runt !== 32'd1) begin errors++; $display("FAIL runt_count: got %0d want 1", st_runt); end
    checks++; if (mvalid_cycles !== 0) begin errors++; $display("FAIL runt_tvalid_cycles: got %0d want 0", mvalid_cycles); end
    drive_frame(4, 64'h5000, 0, st, fs, tmo);
    wait_out(4);
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL runt_next_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {(i == 3), 64'h5000 + 64'(i)})
        begin errors++; $display("FAIL runt_next_beat%0d: got %h want %h", i, got[i], {(i == 3), 64'h5000 + 64'(i)}); end
    end
    checks++; if (st_passed !== 32'd3) begin errors++; $display("FAIL runt_next_passed: got %0d want 3", st_passed); end
  endtask

  task automatic test_simultaneous();
    int st, fs; bit tmo;
    got.delete();
    proto_en = 4'b0100;
    set_meta(MAC_BROADCAST, 4'b0100);
    drive_frame(1, 64'h6000, 0, st, fs, tmo);
    wait_out(1);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL simul1_count: got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== {1'b1, 64'h6000}) begin errors++; $display("FAIL simul1_beat: got %h want %h", got[0], {1'b1, 64'h6000}); end
    end
    checks++; if (st_passed !== 32'd4) begin errors++; $display("FAIL simul1_passed: got %0d want 4", st_passed); end
    // meta and tlast together while in HOLD
    got.delete();
    drive_frame(2, 64'h6100, 1, st, fs, tmo);
    wait_out(2);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL simul2_count: got %0d want 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {(i == 1), 64'h6100 + 64'(i)})
        begin errors++; $display("FAIL simul2_beat%0d: got %h want %h", i, got[i], {(i == 1), 64'h6100 + 64'(i)}); end
    end
    checks++; if (st_passed !== 32'd5) begin errors++; $display("FAIL simul2_passed: got %0d want 5", st_passed); end
  endtask

  task automatic test_mcast_proto();
    int st, fs; bit tmo;
    got.delete();
    mcast_en = 1'b1; proto_en = 4'b0001;
    set_meta(48'h01_00_5E_00_00_01, 4'b0010);
    drive_frame(2, 64'h7000, 1, st, fs, tmo);
    repeat (4) step();
    checks++; if (st_dropped !== 32'd2) begin errors++; $display("FAIL mcast_v6_off_dropped: got %0d want 2", st_dropped); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL mcast_v6_off_count: got %0d want 0", got.size()); end
    proto_en = 4'b0011;
    drive_frame(3, 64'h7100, 0, st, fs, tmo);
    wait_out(3);
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL mcast_pass_count: got %0d want 3", got.size()); end
    checks++; if (st_passed !== 32'd6) begin errors++; $display("FAIL mcast_pass_passed: got %0d want 6", st_passed); end
    got.delete();
    mcast_en = 1'b0;
    drive_frame(3, 64'h7200, 0, st, fs, tmo);
    repeat (4) step();
    checks++; if (st_dropped !== 32'd3) begin errors++; $display("FAIL mcast_off_dropped: got %0d want 3", st_dropped); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL mcast_off_count: got %0d want 0", got.size()); end
    proto_en = 4'b0001;
  endtask

  task automatic test_reset_mid_pass();
    int st, fs; bit tmo;
    got.delete();
    m_if.tready = 1'b0;
    set_meta(LOCAL_MAC, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      s_if.tdata  = 64'h9000 + 64'(i);
      s_if.tvalid = 1'b1;
      s_if.tlast  = 1'b0;
      meta_valid  = (i == 0);
      step();
    end
    s_if.tvalid = 1'b0;
    meta_valid  = 1'b0;
    @(negedge clk);
    checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL midrst_pre_tvalid: got %b want 1", m_if.tvalid); end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b want 0", m_if.tvalid); end
    checks++; if (m_if.tdata !== 64'd0) begin errors++; $display("FAIL midrst_tdata: got %h want 0", m_if.tdata); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL midrst_s_tready: got %b want 0", s_if.tready); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL postrst_tvalid: got %b want 0", m_if.tvalid); end
    checks++; if (st_passed !== 32'd0) begin errors++; $display("FAIL postrst_passed: got %0d want 0", st_passed); end
    checks++; if (st_dropped !== 32'd0) begin errors++; $display("FAIL postrst_dropped: got %0d want 0", st_dropped); end
    checks++; if (st_runt !== 32'd0) begin errors++; $display("FAIL postrst_runt: got %0d want 0", st_runt); end
    step();
    m_if.tready = 1'b1;
    drive_frame(3, 64'h8000, 1, st, fs, tmo);
    wait_out(3);
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL postrst_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {(i == 2), 64'h8000 + 64'(i)})
        begin errors++; $display("FAIL postrst_beat%0d: got %h want %h", i, got[i], {(i == 2), 64'h8000 + 64'(i)}); end
    end
    checks++; if (st_passed !== 32'd1) begin errors++; $display("FAIL postrst_passed_after: got %0d want 1", st_passed); end
  endtask

  initial begin
    test_reset();
    test_local_pass();
    test_drop();
    test_backpressure();
    test_runt();
    test_simultaneous();
    test_mcast_proto();
    test_reset_mid_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
